// File: rtl/call_session_controller.sv
// Purpose: call session sequencer between the UI and the transport layer (dial/answer/reject/end, timeouts, voicemail).
// Latency: every output is registered; an input event on cycle N is visible on cycle N+1.
// Backpressure: one-entry tx register; while it is occupied UI commands stall un-acked and rx replies are dropped.
module call_session_controller #(
    parameter logic [23:0] DIAL_TIMEOUT = 24'd5000000,
    parameter logic [23:0] RING_TIMEOUT = 24'd10000000,
    parameter logic [23:0] VM_MAX       = 24'd15000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] command,
    input  logic [7:0] phn_num,
    output logic       cmd_ack,
    output logic [2:0] inc_command,
    output logic [7:0] caller_id,
    input  logic       rx_valid,
    input  logic [2:0] rx_type,
    input  logic [7:0] rx_num,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [2:0] tx_type,
    output logic [7:0] tx_num,
    output logic [1:0] audio_route,
    output logic [2:0] session_state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DIALING   = 3'd1,
        ST_RINGING   = 3'd2,
        ST_CONNECTED = 3'd3,
        ST_VOICEMAIL = 3'd4
    } state_t;

    localparam logic [2:0] MSG_CALL_REQ = 3'd0;
    localparam logic [2:0] MSG_ACCEPT   = 3'd1;
    localparam logic [2:0] MSG_REJECT   = 3'd2;
    localparam logic [2:0] MSG_HANGUP   = 3'd3;
    localparam logic [2:0] MSG_BUSY     = 3'd4;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_DIAL   = 3'd1;
    localparam logic [2:0] CMD_ANSWER = 3'd2;
    localparam logic [2:0] CMD_REJECT = 3'd3;
    localparam logic [2:0] CMD_END    = 3'd4;

    localparam logic [2:0] UI_CONNECTED = 3'd1;
    localparam logic [2:0] UI_FAILED    = 3'd2;
    localparam logic [2:0] UI_VOICEMAIL = 3'd3;
    localparam logic [2:0] UI_INCOMING  = 3'd5;
    localparam logic [2:0] UI_ENDED     = 3'd6;

    localparam logic [1:0] RT_MUTE = 2'd0;
    localparam logic [1:0] RT_LIVE = 2'd1;
    localparam logic [1:0] RT_VM   = 2'd2;

    state_t      state, state_nx;
    logic [23:0] timer, timer_nx, tmo_limit;
    logic        tmo;
    logic [2:0]  inc_nx;
    logic [7:0]  caller_nx;
    logic [1:0]  route_nx;
    logic        ack_nx;
    logic        send;
    logic [2:0]  send_type;
    logic [7:0]  send_num;

    assign session_state = state;

    // Timeout detection for the timed states. A ">=" compare lets a timeout
    // that lands while the tx register is occupied fire as soon as it drains.
    always_comb begin
        case (state)
            ST_DIALING:   tmo_limit = DIAL_TIMEOUT;
            ST_RINGING:   tmo_limit = RING_TIMEOUT;
            ST_VOICEMAIL: tmo_limit = VM_MAX;
            default:      tmo_limit = '0;
        endcase
        tmo = (tmo_limit != '0) && (timer >= tmo_limit - 24'd1);
    end

    // Next-state and event decode; priority is rx, then timeout, then UI command.
    always_comb begin
        state_nx  = state;
        inc_nx    = inc_command;
        caller_nx = caller_id;
        route_nx  = audio_route;
        ack_nx    = 1'b0;
        send      = 1'b0;
        send_type = MSG_CALL_REQ;
        send_num  = caller_id;
        if (rx_valid) begin
            if (state == ST_IDLE) begin
                if (rx_type == MSG_CALL_REQ) begin
                    caller_nx = rx_num;
                    inc_nx    = UI_INCOMING;
                    state_nx  = ST_RINGING;
                end
            end else if (rx_type == MSG_CALL_REQ) begin
                // Collision: turn the second caller away without disturbing the session.
                send      = !tx_valid;
                send_type = MSG_BUSY;
                send_num  = rx_num;
            end else if (rx_num == caller_id) begin
                case (state)
                    ST_DIALING: begin
                        if (rx_type == MSG_ACCEPT) begin
                            inc_nx   = UI_CONNECTED;
                            route_nx = RT_LIVE;
                            state_nx = ST_CONNECTED;
                        end else if (rx_type == MSG_REJECT || rx_type == MSG_BUSY) begin
                            inc_nx   = UI_FAILED;
                            state_nx = ST_IDLE;
                        end
                    end
                    ST_RINGING: begin
                        if (rx_type == MSG_HANGUP) begin
                            inc_nx   = UI_ENDED;
                            state_nx = ST_IDLE;
                        end
                    end
                    ST_CONNECTED, ST_VOICEMAIL: begin
                        if (rx_type == MSG_HANGUP) begin
                            inc_nx   = UI_ENDED;
                            route_nx = RT_MUTE;
                            state_nx = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (!tx_valid && tmo) begin
            send = 1'b1;
            case (state)
                ST_DIALING: begin
                    send_type = MSG_HANGUP;
                    inc_nx    = UI_FAILED;
                    state_nx  = ST_IDLE;
                end
                ST_RINGING: begin
                    send_type = MSG_ACCEPT;
                    inc_nx    = UI_VOICEMAIL;
                    route_nx  = RT_VM;
                    state_nx  = ST_VOICEMAIL;
                end
                ST_VOICEMAIL: begin
                    send_type = MSG_HANGUP;
                    inc_nx    = UI_ENDED;
                    route_nx  = RT_MUTE;
                    state_nx  = ST_IDLE;
                end
                default: send = 1'b0;
            endcase
        end else if (!tx_valid && command != CMD_NONE) begin
            // Any nonzero command is acked here; ones meaningless in this state are dropped.
            ack_nx = 1'b1;
            case (state)
                ST_IDLE: begin
                    if (command == CMD_DIAL) begin
                        caller_nx = phn_num;
                        send      = 1'b1;
                        send_type = MSG_CALL_REQ;
                        send_num  = phn_num;
                        state_nx  = ST_DIALING;
                    end
                end
                ST_DIALING: begin
                    if (command == CMD_END) begin
                        send      = 1'b1;
                        send_type = MSG_HANGUP;
                        inc_nx    = UI_ENDED;
                        state_nx  = ST_IDLE;
                    end
                end
                ST_RINGING: begin
                    if (command == CMD_ANSWER) begin
                        send      = 1'b1;
                        send_type = MSG_ACCEPT;
                        inc_nx    = UI_CONNECTED;
                        route_nx  = RT_LIVE;
                        state_nx  = ST_CONNECTED;
                    end else if (command == CMD_REJECT) begin
                        send      = 1'b1;
                        send_type = MSG_REJECT;
                        inc_nx    = UI_ENDED;
                        state_nx  = ST_IDLE;
                    end
                end
                ST_CONNECTED: begin
                    if (command == CMD_END) begin
                        send      = 1'b1;
                        send_type = MSG_HANGUP;
                        inc_nx    = UI_ENDED;
                        route_nx  = RT_MUTE;
                        state_nx  = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
        if (state_nx != state)
            timer_nx = '0;
        else if (&timer)
            timer_nx = timer;
        else
            timer_nx = timer + 24'd1;
    end

    // State, UI outputs, timer and the one-entry tx register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            inc_command <= '0;
            caller_id   <= '0;
            audio_route <= '0;
            cmd_ack     <= 1'b0;
            tx_valid    <= 1'b0;
            tx_type     <= '0;
            tx_num      <= '0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            inc_command <= inc_nx;
            caller_id   <= caller_nx;
            audio_route <= route_nx;
            cmd_ack     <= ack_nx;
            if (send) begin
                tx_valid <= 1'b1;
                tx_type  <= send_type;
                tx_num   <= send_num;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_call_session_controller.sv
// Bench for call_session_controller: directed call scenarios followed by random traffic,
// scored against a rule-table model of the call protocol.
module tb_call_session_controller;

    localparam logic [23:0] DT = 24'd10;
    localparam logic [23:0] RT = 24'd20;
    localparam logic [23:0] VT = 24'd30;

    localparam int S_IDLE = 0, S_DIAL = 1, S_RING = 2, S_CONN = 3, S_VM = 4;
    localparam int M_REQ = 0, M_ACC = 1, M_REJ = 2, M_HUP = 3, M_BUSY = 4;
    localparam int EV_NONE = 0, EV_INC = 1, EV_ACC = 2, EV_REJ = 3, EV_HUP = 4, EV_TMO = 5,
                   EV_DIAL = 6, EV_ANS = 7, EV_DECL = 8, EV_END = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] command;
    logic [7:0] phn_num;
    logic       cmd_ack;
    logic [2:0] inc_command;
    logic [7:0] caller_id;
    logic       rx_valid;
    logic [2:0] rx_type;
    logic [7:0] rx_num;
    logic       tx_valid;
    logic       tx_ready;
    logic [2:0] tx_type;
    logic [7:0] tx_num;
    logic [1:0] audio_route;
    logic [2:0] session_state;

    call_session_controller #(
        .DIAL_TIMEOUT(DT),
        .RING_TIMEOUT(RT),
        .VM_MAX(VT)
    ) dut (
        .clk(clk), .reset(reset), .command(command), .phn_num(phn_num), .cmd_ack(cmd_ack),
        .inc_command(inc_command), .caller_id(caller_id), .rx_valid(rx_valid), .rx_type(rx_type),
        .rx_num(rx_num), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_type(tx_type),
        .tx_num(tx_num), .audio_route(audio_route), .session_state(session_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int state; int inc; int caller; int route; int ack; int txv;
    } snap_t;
    typedef struct {
        int typ; int num;
    } msg_t;
    typedef struct {
        int nxt; int inc; int route; int msg;
    } rule_t;

    snap_t snap_q[$];
    msg_t  tx_q[$];
    bit    mon_en = 1'b0;

    // Reference model state.
    int m_state, m_inc, m_caller, m_route, m_ack, m_txv, m_timer;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Protocol rule table: (state, event) -> next state, UI code, audio route, message to send.
    // -1 means "unchanged" / "nothing sent"; nxt == -1 means the event has no effect.
    function automatic rule_t mk(input int n, input int i, input int r, input int m);
        rule_t x;
        x.nxt = n; x.inc = i; x.route = r; x.msg = m;
        return x;
    endfunction

    function automatic rule_t rule(input int st, input int ev);
        case (st * 16 + ev)
            S_IDLE * 16 + EV_INC:  return mk(S_RING, 5, -1, -1);
            S_IDLE * 16 + EV_DIAL: return mk(S_DIAL, -1, -1, M_REQ);
            S_DIAL * 16 + EV_ACC:  return mk(S_CONN, 1, 1, -1);
            S_DIAL * 16 + EV_REJ:  return mk(S_IDLE, 2, -1, -1);
            S_DIAL * 16 + EV_END:  return mk(S_IDLE, 6, -1, M_HUP);
            S_DIAL * 16 + EV_TMO:  return mk(S_IDLE, 2, -1, M_HUP);
            S_RING * 16 + EV_ANS:  return mk(S_CONN, 1, 1, M_ACC);
            S_RING * 16 + EV_DECL: return mk(S_IDLE, 6, -1, M_REJ);
            S_RING * 16 + EV_HUP:  return mk(S_IDLE, 6, -1, -1);
            S_RING * 16 + EV_TMO:  return mk(S_VM, 3, 2, M_ACC);
            S_CONN * 16 + EV_END:  return mk(S_IDLE, 6, 0, M_HUP);
            S_CONN * 16 + EV_HUP:  return mk(S_IDLE, 6, 0, -1);
            S_VM * 16 + EV_HUP:    return mk(S_IDLE, 6, 0, -1);
            S_VM * 16 + EV_TMO:    return mk(S_IDLE, 6, 0, M_HUP);
            default:               return mk(-1, -1, -1, -1);
        endcase
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_inc = 0; m_caller = 0; m_route = 0;
        m_ack = 0; m_txv = 0; m_timer = 0;
    endtask

    task automatic send_msg(input int typ, input int num);
        msg_t m;
        m.typ = typ; m.num = num;
        tx_q.push_back(m);
        m_txv = 1;
    endtask

    // One clock of protocol behaviour given this cycle's inputs.
    task automatic model_step(input int c, input int p, input int rv, input int rt,
                              input int rn, input int rdy);
        int    ev, lim, nxt;
        bit    busy;
        rule_t r;
        busy  = (m_txv != 0);
        ev    = EV_NONE;
        m_ack = 0;
        lim   = (m_state == S_DIAL) ? int'(DT) : (m_state == S_RING) ? int'(RT) :
                (m_state == S_VM) ? int'(VT) : 0;
        if (busy && rdy != 0) m_txv = 0;
        if (rv != 0) begin
            if (m_state == S_IDLE) begin
                if (rt == M_REQ) ev = EV_INC;
            end else if (rt == M_REQ) begin
                if (!busy) send_msg(M_BUSY, rn);
            end else if (rn == m_caller) begin
                if (rt == M_ACC) ev = EV_ACC;
                else if (rt == M_HUP) ev = EV_HUP;
                else if (rt == M_REJ || rt == M_BUSY) ev = EV_REJ;
            end
        end else if (!busy && lim > 0 && m_timer >= lim - 1) begin
            ev = EV_TMO;
        end else if (!busy && c != 0) begin
            m_ack = 1;
            if (c >= 1 && c <= 4) ev = EV_DIAL + c - 1;
        end
        r   = rule(m_state, ev);
        nxt = m_state;
        if (r.nxt >= 0) begin
            if (ev == EV_INC)  m_caller = rn;
            if (ev == EV_DIAL) m_caller = p;
            if (r.inc >= 0)   m_inc = r.inc;
            if (r.route >= 0) m_route = r.route;
            if (r.msg >= 0)   send_msg(r.msg, m_caller);
            nxt = r.nxt;
        end
        if (nxt != m_state) m_timer = 0;
        else if (m_timer < 32'hFFFFFF) m_timer = m_timer + 1;
        m_state = nxt;
    endtask

    // Drive one cycle of stimulus, record what the DUT should show now, then advance the model.
    task automatic cycle(input logic [2:0] c, input logic [7:0] p, input logic rv,
                         input logic [2:0] rt, input logic [7:0] rn, input logic rdy);
        snap_t s;
        @(posedge clk);
        #1;
        command = c; phn_num = p; rx_valid = rv; rx_type = rt; rx_num = rn; tx_ready = rdy;
        s.state = m_state; s.inc = m_inc; s.caller = m_caller;
        s.route = m_route; s.ack = m_ack; s.txv = m_txv;
        snap_q.push_back(s);
        mon_en = 1'b1;
        model_step(int'(c), int'(p), int'(rv), int'(rt), int'(rn), int'(rdy));
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) cycle(3'd0, 8'h00, 1'b0, 3'd0, 8'h00, rdy);
    endtask

    // Monitor: compares the registered outputs every cycle and each delivered tx message.
    snap_t exp_s;
    msg_t  exp_m;
    always @(negedge clk) begin
        if (mon_en) begin
            if (snap_q.size() == 0) begin
                check("snapshot_underflow", 1, 0);
            end else begin
                exp_s = snap_q.pop_front();
                check("session_state", int'(session_state), exp_s.state);
                check("inc_command", int'(inc_command), exp_s.inc);
                check("caller_id", int'(caller_id), exp_s.caller);
                check("audio_route", int'(audio_route), exp_s.route);
                check("cmd_ack", int'(cmd_ack), exp_s.ack);
                check("tx_valid", int'(tx_valid), exp_s.txv);
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected", int'(tx_type), -1);
                end else begin
                    exp_m = tx_q.pop_front();
                    check("tx_type", int'(tx_type), exp_m.typ);
                    check("tx_num", int'(tx_num), exp_m.num);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, int'(session_state), 0);
        check({tag, "_inc"}, int'(inc_command), 0);
        check({tag, "_caller"}, int'(caller_id), 0);
        check({tag, "_tx_valid"}, int'(tx_valid), 0);
        check({tag, "_tx_type"}, int'(tx_type), 0);
        check({tag, "_tx_num"}, int'(tx_num), 0);
        check({tag, "_route"}, int'(audio_route), 0);
        check({tag, "_ack"}, int'(cmd_ack), 0);
    endtask

    initial begin
        logic [2:0] c, rt;
        logic [7:0] p, rn;
        logic       rv, rdy;
        logic [7:0] nums [4];
        nums[0] = 8'h04; nums[1] = 8'h07; nums[2] = 8'h21; nums[3] = 8'h33;

        reset = 1'b1; command = '0; phn_num = '0; rx_valid = 1'b0;
        rx_type = '0; rx_num = '0; tx_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 reset = 1'b0;

        // Outgoing call: CALL_REQ held under backpressure, then remote accepts.
        cycle(3'd1, 8'h04, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(3, 1'b0);
        idle(1, 1'b1);
        cycle(3'd0, 8'h00, 1'b1, 3'd1, 8'h04, 1'b1);
        idle(2, 1'b1);

        // Collision while connected, then hang-up stalled behind the BUSY reply.
        cycle(3'd0, 8'h00, 1'b1, 3'd0, 8'h33, 1'b0);
        repeat (4) cycle(3'd4, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
        repeat (2) cycle(3'd4, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1);
        idle(2, 1'b1);

        // Incoming call answered, then remote hangs up.
        cycle(3'd0, 8'h00, 1'b1, 3'd0, 8'h21, 1'b1);
        idle(2, 1'b1);
        cycle(3'd2, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1);
        idle(2, 1'b1);
        cycle(3'd0, 8'h00, 1'b1, 3'd3, 8'h21, 1'b1);
        idle(2, 1'b1);

        // Unanswered call: divert to voicemail, then voicemail record limit.
        cycle(3'd0, 8'h00, 1'b1, 3'd0, 8'h55, 1'b1);
        idle(60, 1'b1);

        // Dial timeout, then a dial answered with BUSY.
        cycle(3'd1, 8'h07, 1'b0, 3'd0, 8'h00, 1'b1);
        idle(14, 1'b1);
        cycle(3'd1, 8'h08, 1'b0, 3'd0, 8'h00, 1'b1);
        idle(2, 1'b1);
        cycle(3'd0, 8'h00, 1'b1, 3'd4, 8'h08, 1'b1);
        idle(2, 1'b1);

        // Answer and remote hang-up in the same cycle: rx wins, nothing sent.
        cycle(3'd0, 8'h00, 1'b1, 3'd0, 8'h21, 1'b1);
        idle(1, 1'b1);
        cycle(3'd2, 8'h00, 1'b1, 3'd3, 8'h21, 1'b1);
        idle(2, 1'b1);

        // Reset mid-call with a message stuck in the tx register.
        cycle(3'd1, 8'h04, 1'b0, 3'd0, 8'h00, 1'b1);
        idle(1, 1'b1);
        cycle(3'd0, 8'h00, 1'b1, 3'd1, 8'h04, 1'b1);
        cycle(3'd0, 8'h00, 1'b1, 3'd0, 8'h33, 1'b0);
        idle(1, 1'b0);
        check("pre_reset_state", int'(session_state), 3);
        check("pre_reset_tx_valid", int'(tx_valid), 1);
        #1;
        mon_en = 1'b0;
        snap_q.delete();
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #3 reset = 1'b0;
        tx_q.delete();
        model_reset();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            c   = ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(1, 7));
            p   = nums[$urandom_range(0, 3)];
            rv  = ($urandom_range(0, 9) == 0);
            rt  = 3'($urandom_range(0, 4));
            rn  = ($urandom_range(0, 2) != 0) ? 8'(m_caller) : nums[$urandom_range(0, 3)];
            rdy = ($urandom_range(0, 3) != 0);
            cycle(c, p, rv, rt, rn, rdy);
        end
        idle(8, 1'b1);
        @(posedge clk);
        #1 mon_en = 1'b0;
        check("tx_queue_residue", tx_q.size(), m_txv);
        check("snapshot_residue", snap_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
